pmips_l0_core: RTL and testbench
================================

# pmips_l0_core

Five-stage pipelined 16-bit PMIPS processor core (IF, ID, EX, MEM, WB) with eight 16-bit registers, full forwarding, load-use stall and branch flush. It fetches from an external combinational instruction ROM and accesses an external data memory with memory-mapped switch/7-segment I/O. It also exports pipeline-internal debug taps for the system testbench.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- imemaddr  out  16  current PC (byte address).
- imemrdata  in  16  instruction at imemaddr, combinational.
- dmemaddr  out  16  EX/MEM ALU result (MEM-stage address).
- dmemwdata  out  16  EX/MEM store data.
- dmemwrite  out  1  high in MEM for sw; memory writes on the clock edge.
- dmemread  out  1  high in MEM for lw.
- dmemrdata  in  16  load data, combinational from dmemaddr.
- aluresult  out  16  combinational EX-stage ALU output.
- debug  out  16  ALUOut: EX/MEM ALU result register.
- stall  out  1  load-use stall asserted this cycle.
- debug2  out  16  IF/ID instruction.
- debug3  out  16  ID/EX instruction.
- debug4  out  16  EX/MEM instruction.
- debug5  out  1  WB register-write enable.
- debug6  out  16  WB write-back data.
- debug7  out  16  EX/MEM ALU result (same value as debug).

## Operation
- Fields: op[15:13], rs[12:10], rt[9:7], rd[6:4], funct[3:0], imm7[6:0] sign-extended, imm13[12:0].
- op 000 R-type: rd = rs OP rt. funct 0 add, 1 sub, 2 and, 3 or, 4 slt (signed; result 1/0). Other funct values: no write.
- op 001 lw: rt = M[rs+sext(imm7)].
- op 010 sw: M[rs+sext(imm7)] = rt.
- op 011 beq: if rs==rt, PC = PC+2+(sext(imm7)<<1).
- op 100 addi: rt = rs+sext(imm7).
- op 101 slti: rt = (rs <s sext(imm7)).
- op 110 j: PC = {2'b00, imm13, 1'b0}.
- op 111: NOP.
- Arithmetic is 16-bit two's complement and wraps; no overflow trap.
- 0x0000 (add $0,$0,$0) is the NOP/bubble encoding.
- Register file: 8×16 registers. $0 always reads 0, and writes to it are ignored.
- The register file writes on the clock edge. ID reads see same-cycle WB data through internal bypass.
- Forwarding into EX operands: EX/MEM result first, then MEM/WB data, then the register value. No forwarding for source $0.
- Load-use hazard: ID instruction reads the rt target of a lw in EX. Response: stall=1, PC and IF/ID hold, and a bubble is inserted into ID/EX for one cycle.
- Branches and jumps resolve in EX. When taken, the PC loads the target and IF/ID and ID/EX are flushed to NOP (2-cycle penalty). Not-taken: no penalty.
- Taken branch/jump beats a simultaneous stall.

## Timing
- PC advances by 2 each non-stalled cycle.
- Instruction fetched in cycle n has its ALU result at aluresult in n+2 and is in MEM in n+3. It writes its register on the edge ending n+4.
- dmemaddr, dmemwdata, dmemread, dmemwrite are driven from EX/MEM registers only.
- Reset (synchronous) sets PC=RESET_PC and clears all pipeline registers to NOP with control zero. It also clears every register to 0. stall, dmemwrite, dmemread and debug5 are 0 after reset.
- Reset mid-operation discards all in-flight instructions. No store may be issued in the cycle after reset.

## Test plan
- Reset with PC mid-program -> next cycle imemaddr=0; debug2, debug3, debug4 all 0; dmemwrite=0.
- addi $1,$0,5; addi $2,$0,3; add $3,$1,$2 back-to-back -> aluresult 5, 3, 8 on consecutive cycles (forwarding). WB writes $3=8, seen as debug5=1, debug6=8.
- sw $3,4($0) then lw $4,4($0); add $5,$4,$4 -> dmemwrite=1, dmemaddr=4, dmemwdata=8. Then stall=1 for exactly one cycle, and $5=16.
- beq $1,$1,+2 followed by two addi -> both addi flushed (never written). PC jumps to branch PC+6.
- j with imm13=0 -> infinite loop; imemaddr returns to 0 every 3 cycles. No register writes from the two flushed instructions.
- slt/slti with -1 vs 1 -> result 1 (signed compare). sub 0-1 -> 16'hFFFF.

Source files
------------

// File: rtl/pmips_l0_core.sv
// Five-stage pipelined 16-bit PMIPS core: IF/ID/EX/MEM/WB with full forwarding,
// load-use stall, EX-resolved branch/jump flush and debug taps of pipeline state.
module pmips_l0_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] imemaddr,
  input  logic [15:0] imemrdata,
  output logic [15:0] dmemaddr,
  output logic [15:0] dmemwdata,
  output logic        dmemwrite,
  output logic        dmemread,
  input  logic [15:0] dmemrdata,
  output logic [15:0] aluresult,
  output logic [15:0] debug,
  output logic        stall,
  output logic [15:0] debug2,
  output logic [15:0] debug3,
  output logic [15:0] debug4,
  output logic        debug5,
  output logic [15:0] debug6,
  output logic [15:0] debug7
);

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SLTI = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  // Returns {write_enable, dest}; a write to $0 is reported as no write at all.
  function automatic logic [3:0] dest_info(input logic [2:0] op, input logic [2:0] rt,
                                           input logic [2:0] rd, input logic [3:0] funct);
    logic       we;
    logic [2:0] d;
    we = 1'b0;
    d  = 3'b000;
    case (op)
      OP_R: begin
        we = (funct <= 4'd4);
        d  = rd;
      end
      OP_LW, OP_ADDI, OP_SLTI: begin
        we = 1'b1;
        d  = rt;
      end
      default: ;
    endcase
    return {we && (d != 3'b000), d};
  endfunction

  function automatic logic uses_rs(input logic [2:0] op);
    return op <= OP_SLTI;
  endfunction

  function automatic logic uses_rt(input logic [2:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  logic [15:0] pc;
  logic [15:0] if_id_instr, if_id_pc;
  logic [15:0] id_ex_instr, id_ex_pc, id_ex_a, id_ex_b;
  logic [15:0] ex_mem_instr, ex_mem_alu, ex_mem_b;
  logic        mem_wb_we;
  logic [2:0]  mem_wb_dest;
  logic [15:0] mem_wb_data;
  logic [15:0] regs [8];

  // ID stage: register read with same-cycle write-back bypass
  logic [2:0]  id_op, id_rs, id_rt;
  logic [15:0] rd_a, rd_b;
  logic        load_use;

  assign id_op = if_id_instr[15:13];
  assign id_rs = if_id_instr[12:10];
  assign id_rt = if_id_instr[9:7];

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (id_rs != 3'b000)
      rd_a = (mem_wb_we && mem_wb_dest == id_rs) ? mem_wb_data : regs[id_rs];
    if (id_rt != 3'b000)
      rd_b = (mem_wb_we && mem_wb_dest == id_rt) ? mem_wb_data : regs[id_rt];
  end

  // EX stage
  logic [2:0]  ex_op, ex_rs, ex_rt;
  logic [15:0] ex_imm, fwd_a, fwd_b, alu, target;
  logic        taken;
  logic [3:0]  ex_mem_info;
  logic        ex_mem_is_lw;

  assign ex_op  = id_ex_instr[15:13];
  assign ex_rs  = id_ex_instr[12:10];
  assign ex_rt  = id_ex_instr[9:7];
  assign ex_imm = {{9{id_ex_instr[6]}}, id_ex_instr[6:0]};

  assign ex_mem_info  = dest_info(ex_mem_instr[15:13], ex_mem_instr[9:7],
                                  ex_mem_instr[6:4], ex_mem_instr[3:0]);
  assign ex_mem_is_lw = (ex_mem_instr[15:13] == OP_LW);

  // A load in MEM has no data yet; the load-use stall keeps consumers out of EX then.
  assign load_use = (ex_op == OP_LW) && (ex_rt != 3'b000) &&
                    ((uses_rs(id_op) && id_rs == ex_rt) || (uses_rt(id_op) && id_rt == ex_rt));

  always_comb begin
    fwd_a = id_ex_a;
    fwd_b = id_ex_b;
    if (ex_rs != 3'b000) begin
      if (ex_mem_info[3] && !ex_mem_is_lw && ex_mem_info[2:0] == ex_rs) fwd_a = ex_mem_alu;
      else if (mem_wb_we && mem_wb_dest == ex_rs)                      fwd_a = mem_wb_data;
    end
    if (ex_rt != 3'b000) begin
      if (ex_mem_info[3] && !ex_mem_is_lw && ex_mem_info[2:0] == ex_rt) fwd_b = ex_mem_alu;
      else if (mem_wb_we && mem_wb_dest == ex_rt)                      fwd_b = mem_wb_data;
    end
  end

  always_comb begin
    alu    = '0;
    taken  = 1'b0;
    target = id_ex_pc + 16'd2 + {ex_imm[14:0], 1'b0};
    case (ex_op)
      OP_R: begin
        case (id_ex_instr[3:0])
          4'd0:    alu = fwd_a + fwd_b;
          4'd1:    alu = fwd_a - fwd_b;
          4'd2:    alu = fwd_a & fwd_b;
          4'd3:    alu = fwd_a | fwd_b;
          4'd4:    alu = {15'b0, $signed(fwd_a) < $signed(fwd_b)};
          default: alu = '0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu = fwd_a + ex_imm;
      OP_SLTI: alu = {15'b0, $signed(fwd_a) < $signed(ex_imm)};
      OP_BEQ: begin
        alu   = fwd_a - fwd_b;
        taken = (fwd_a == fwd_b);
      end
      OP_J: begin
        taken  = 1'b1;
        target = {2'b00, id_ex_instr[12:0], 1'b0};
      end
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= RESET_PC;
      if_id_instr  <= '0;
      if_id_pc     <= '0;
      id_ex_instr  <= '0;
      id_ex_pc     <= '0;
      id_ex_a      <= '0;
      id_ex_b      <= '0;
      ex_mem_instr <= '0;
      ex_mem_alu   <= '0;
      ex_mem_b     <= '0;
      mem_wb_we    <= 1'b0;
      mem_wb_dest  <= '0;
      mem_wb_data  <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (mem_wb_we) regs[mem_wb_dest] <= mem_wb_data;

      mem_wb_we    <= ex_mem_info[3];
      mem_wb_dest  <= ex_mem_info[2:0];
      mem_wb_data  <= ex_mem_is_lw ? dmemrdata : ex_mem_alu;

      ex_mem_instr <= id_ex_instr;
      ex_mem_alu   <= alu;
      ex_mem_b     <= fwd_b;

      if (taken) begin
        pc          <= target;
        if_id_instr <= '0;
        if_id_pc    <= '0;
        id_ex_instr <= '0;
        id_ex_pc    <= '0;
        id_ex_a     <= '0;
        id_ex_b     <= '0;
      end else if (load_use) begin
        id_ex_instr <= '0;
        id_ex_pc    <= '0;
        id_ex_a     <= '0;
        id_ex_b     <= '0;
      end else begin
        pc          <= pc + 16'd2;
        if_id_instr <= imemrdata;
        if_id_pc    <= pc;
        id_ex_instr <= if_id_instr;
        id_ex_pc    <= if_id_pc;
        id_ex_a     <= rd_a;
        id_ex_b     <= rd_b;
      end
    end
  end

  assign imemaddr  = pc;
  assign dmemaddr  = ex_mem_alu;
  assign dmemwdata = ex_mem_b;
  assign dmemwrite = (ex_mem_instr[15:13] == OP_SW);
  assign dmemread  = ex_mem_is_lw;
  assign aluresult = alu;
  assign stall     = load_use;
  assign debug     = ex_mem_alu;
  assign debug2    = if_id_instr;
  assign debug3    = id_ex_instr;
  assign debug4    = ex_mem_instr;
  assign debug5    = mem_wb_we;
  assign debug6    = mem_wb_data;
  assign debug7    = ex_mem_alu;

endmodule

// File: tb/tb_pmips_l0_core.sv
// Directed bench for pmips_l0_core: small programs in a ROM model, cycle-exact checks
// of fetch address, ALU/forwarding, load-use stall, flushes and write-back taps.
module tb_pmips_l0_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imemaddr, imemrdata, dmemaddr, dmemwdata, dmemrdata, aluresult;
  logic        dmemwrite, dmemread, stall, debug5;
  logic [15:0] debug, debug2, debug3, debug4, debug6, debug7;

  logic [15:0] rom  [0:127];
  logic [15:0] dmem [0:127];

  int n_tests = 0;
  int n_fail  = 0;

  pmips_l0_core dut (
    .clock(clock), .reset(reset),
    .imemaddr(imemaddr), .imemrdata(imemrdata),
    .dmemaddr(dmemaddr), .dmemwdata(dmemwdata), .dmemwrite(dmemwrite),
    .dmemread(dmemread), .dmemrdata(dmemrdata),
    .aluresult(aluresult), .debug(debug), .stall(stall),
    .debug2(debug2), .debug3(debug3), .debug4(debug4),
    .debug5(debug5), .debug6(debug6), .debug7(debug7)
  );

  // clock / memories
  always #5 clock = ~clock;

  assign imemrdata = rom[imemaddr[7:1]];
  assign dmemrdata = dmem[dmemaddr[7:1]];
  always @(posedge clock) if (dmemwrite) dmem[dmemaddr[7:1]] <= dmemwdata;

  function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [3:0] f);
    return {3'b000, rs, rt, rd, f};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [6:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // driver tasks
  task automatic clear_prog();
    for (int i = 0; i < 128; i++) begin
      rom[i]  = 16'hE000;
      dmem[i] = 16'h0000;
    end
  endtask

  // Returns at the negedge inside cycle 0 (first fetch of address 0).
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    clear_prog();
    for (int i = 0; i < 32; i++) rom[i] = 16'h4000;
    do_reset();
    step(5);
    n_tests++; if (imemaddr !== 16'd10) begin n_fail++; $display("FAIL pre_reset_pc: got %h expected %h", imemaddr, 16'd10); end
    n_tests++; if (dmemwrite !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sw: got %b expected 1", dmemwrite); end
    reset = 1'b1;
    @(negedge clock);
    n_tests++; if (imemaddr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", imemaddr); end
    n_tests++; if (debug2 !== 16'h0000) begin n_fail++; $display("FAIL reset_ifid: got %h expected 0000", debug2); end
    n_tests++; if (debug3 !== 16'h0000) begin n_fail++; $display("FAIL reset_idex: got %h expected 0000", debug3); end
    n_tests++; if (debug4 !== 16'h0000) begin n_fail++; $display("FAIL reset_exmem: got %h expected 0000", debug4); end
    n_tests++; if (dmemwrite !== 1'b0) begin n_fail++; $display("FAIL reset_dmemwrite: got %b expected 0", dmemwrite); end
    n_tests++; if (dmemread !== 1'b0) begin n_fail++; $display("FAIL reset_dmemread: got %b expected 0", dmemread); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_tests++; if (debug5 !== 1'b0) begin n_fail++; $display("FAIL reset_debug5: got %b expected 0", debug5); end
    n_tests++; if (debug7 !== 16'h0000) begin n_fail++; $display("FAIL reset_debug7: got %h expected 0000", debug7); end
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    clear_prog();
    rom[0] = enc_i(3'b100, 3'd0, 3'd1, 7'd5);
    rom[1] = enc_i(3'b100, 3'd0, 3'd2, 7'd3);
    rom[2] = enc_r(3'd1, 3'd2, 3'd3, 4'd0);
    do_reset();
    step(1);
    n_tests++; if (debug2 !== 16'h8085) begin n_fail++; $display("FAIL fwd_ifid: got %h expected 8085", debug2); end
    step(1);
    n_tests++; if (aluresult !== 16'd5) begin n_fail++; $display("FAIL fwd_alu0: got %h expected 0005", aluresult); end
    step(1);
    n_tests++; if (aluresult !== 16'd3) begin n_fail++; $display("FAIL fwd_alu1: got %h expected 0003", aluresult); end
    n_tests++; if (debug !== 16'd5) begin n_fail++; $display("FAIL fwd_debug: got %h expected 0005", debug); end
    step(1);
    n_tests++; if (aluresult !== 16'd8) begin n_fail++; $display("FAIL fwd_alu2: got %h expected 0008", aluresult); end
    n_tests++; if (debug5 !== 1'b1 || debug6 !== 16'd5) begin n_fail++; $display("FAIL fwd_wb1: got %b/%h expected 1/0005", debug5, debug6); end
    step(2);
    n_tests++; if (debug5 !== 1'b1 || debug6 !== 16'd8) begin n_fail++; $display("FAIL fwd_wb3: got %b/%h expected 1/0008", debug5, debug6); end
  endtask

  task automatic test_load_use();
    clear_prog();
    rom[0] = enc_i(3'b100, 3'd0, 3'd3, 7'd8);
    rom[1] = enc_i(3'b010, 3'd0, 3'd3, 7'd4);
    rom[2] = enc_i(3'b001, 3'd0, 3'd4, 7'd4);
    rom[3] = enc_r(3'd4, 3'd4, 3'd5, 4'd0);
    do_reset();
    step(3);
    n_tests++; if (stall !== 1'b0 || imemaddr !== 16'd6) begin n_fail++; $display("FAIL lu_c3: got stall %b pc %h expected 0/0006", stall, imemaddr); end
    step(1);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall); end
    n_tests++; if (dmemwrite !== 1'b1 || dmemaddr !== 16'd4 || dmemwdata !== 16'd8) begin
      n_fail++; $display("FAIL lu_store: got we %b addr %h data %h expected 1/0004/0008", dmemwrite, dmemaddr, dmemwdata); end
    n_tests++; if (imemaddr !== 16'd8) begin n_fail++; $display("FAIL lu_pc4: got %h expected 0008", imemaddr); end
    step(1);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end: got %b expected 0", stall); end
    n_tests++; if (imemaddr !== 16'd8) begin n_fail++; $display("FAIL lu_pc_hold: got %h expected 0008", imemaddr); end
    n_tests++; if (debug3 !== 16'h0000) begin n_fail++; $display("FAIL lu_bubble: got %h expected 0000", debug3); end
    n_tests++; if (dmemread !== 1'b1 || dmem[2] !== 16'd8) begin n_fail++; $display("FAIL lu_load: got rd %b mem %h expected 1/0008", dmemread, dmem[2]); end
    step(1);
    n_tests++; if (aluresult !== 16'd16 || stall !== 1'b0) begin n_fail++; $display("FAIL lu_add: got %h stall %b expected 0010/0", aluresult, stall); end
    step(2);
    n_tests++; if (debug5 !== 1'b1 || debug6 !== 16'd16) begin n_fail++; $display("FAIL lu_wb: got %b/%h expected 1/0010", debug5, debug6); end
  endtask

  task automatic test_branch();
    clear_prog();
    rom[0] = enc_i(3'b100, 3'd0, 3'd1, 7'd1);
    rom[1] = enc_i(3'b011, 3'd1, 3'd1, 7'd2);
    rom[2] = enc_i(3'b100, 3'd0, 3'd6, 7'd9);
    rom[3] = enc_i(3'b100, 3'd0, 3'd7, 7'd9);
    rom[4] = enc_i(3'b100, 3'd0, 3'd2, 7'd4);
    do_reset();
    step(3);
    n_tests++; if (imemaddr !== 16'd6) begin n_fail++; $display("FAIL br_pc3: got %h expected 0006", imemaddr); end
    step(1);
    n_tests++; if (imemaddr !== 16'd8) begin n_fail++; $display("FAIL br_target: got %h expected 0008", imemaddr); end
    n_tests++; if (debug2 !== 16'h0000 || debug3 !== 16'h0000) begin n_fail++; $display("FAIL br_flush: got %h/%h expected 0000/0000", debug2, debug3); end
    step(1);
    n_tests++; if (debug5 !== 1'b0) begin n_fail++; $display("FAIL br_wb5: got %b expected 0", debug5); end
    step(1);
    n_tests++; if (aluresult !== 16'd4) begin n_fail++; $display("FAIL br_alu6: got %h expected 0004", aluresult); end
    n_tests++; if (debug5 !== 1'b0) begin n_fail++; $display("FAIL br_wb6: got %b expected 0", debug5); end
    step(1);
    n_tests++; if (debug5 !== 1'b0) begin n_fail++; $display("FAIL br_wb7: got %b expected 0", debug5); end
    step(1);
    n_tests++; if (debug5 !== 1'b1 || debug6 !== 16'd4) begin n_fail++; $display("FAIL br_wb8: got %b/%h expected 1/0004", debug5, debug6); end
  endtask

  task automatic test_jump();
    logic [15:0] exp_pc [9];
    exp_pc = '{16'd0, 16'd2, 16'd4, 16'd0, 16'd2, 16'd4, 16'd0, 16'd2, 16'd4};
    clear_prog();
    rom[0] = 16'hC000;
    rom[1] = enc_i(3'b100, 3'd0, 3'd1, 7'd1);
    rom[2] = enc_i(3'b100, 3'd0, 3'd2, 7'd2);
    do_reset();
    for (int c = 0; c < 9; c++) begin
      n_tests++; if (imemaddr !== exp_pc[c]) begin n_fail++; $display("FAIL jmp_pc c%0d: got %h expected %h", c, imemaddr, exp_pc[c]); end
      n_tests++; if (debug5 !== 1'b0) begin n_fail++; $display("FAIL jmp_wb c%0d: got %b expected 0", c, debug5); end
      step(1);
    end
  endtask

  task automatic test_slt_sub();
    clear_prog();
    rom[0] = enc_i(3'b100, 3'd0, 3'd1, 7'h7F);
    rom[1] = enc_i(3'b100, 3'd0, 3'd2, 7'd1);
    rom[2] = enc_r(3'd1, 3'd2, 3'd3, 4'd4);
    rom[3] = enc_i(3'b101, 3'd1, 3'd4, 7'd1);
    rom[4] = enc_r(3'd0, 3'd2, 3'd5, 4'd1);
    rom[5] = enc_r(3'd2, 3'd1, 3'd6, 4'd4);
    rom[6] = enc_r(3'd1, 3'd2, 3'd7, 4'd5);
    do_reset();
    step(2);
    n_tests++; if (aluresult !== 16'hFFFF) begin n_fail++; $display("FAIL slt_addi_neg: got %h expected ffff", aluresult); end
    step(2);
    n_tests++; if (aluresult !== 16'd1) begin n_fail++; $display("FAIL slt_signed: got %h expected 0001", aluresult); end
    step(1);
    n_tests++; if (aluresult !== 16'd1) begin n_fail++; $display("FAIL slti_signed: got %h expected 0001", aluresult); end
    step(1);
    n_tests++; if (aluresult !== 16'hFFFF) begin n_fail++; $display("FAIL sub_wrap: got %h expected ffff", aluresult); end
    n_tests++; if (debug5 !== 1'b1 || debug6 !== 16'd1) begin n_fail++; $display("FAIL slt_wb: got %b/%h expected 1/0001", debug5, debug6); end
    step(1);
    n_tests++; if (aluresult !== 16'd0) begin n_fail++; $display("FAIL slt_false: got %h expected 0000", aluresult); end
    step(2);
    n_tests++; if (debug5 !== 1'b1 || debug6 !== 16'd0) begin n_fail++; $display("FAIL slt_false_wb: got %b/%h expected 1/0000", debug5, debug6); end
    step(1);
    n_tests++; if (debug5 !== 1'b0) begin n_fail++; $display("FAIL bad_funct_wb: got %b expected 0", debug5); end
  endtask

  task automatic test_zero_reg();
    clear_prog();
    rom[0] = enc_i(3'b100, 3'd0, 3'd0, 7'd5);
    rom[1] = enc_r(3'd0, 3'd0, 3'd1, 4'd0);
    rom[3] = enc_r(3'd0, 3'd0, 3'd2, 4'd0);
    do_reset();
    step(2);
    n_tests++; if (aluresult !== 16'd5) begin n_fail++; $display("FAIL zero_addi: got %h expected 0005", aluresult); end
    step(1);
    n_tests++; if (aluresult !== 16'd0) begin n_fail++; $display("FAIL zero_nofwd: got %h expected 0000", aluresult); end
    step(2);
    n_tests++; if (aluresult !== 16'd0) begin n_fail++; $display("FAIL zero_nobypass: got %h expected 0000", aluresult); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_prog();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_jump();
    test_slt_sub();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
